// File: rtl/inst_fetch.sv
// Multi-cycle instruction fetch stage: PC, req/ready fetch from instruction memory,
// instruction register with decoded fields, consumer stall and branch/jump redirect.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fetchPc_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        instValid_q;
    logic [31:0] instCount_q;

    logic [31:0] redirectTarget;
    logic [31:0] fetchPcPlus4;

    assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
    assign fetchPcPlus4   = fetchPc_q + 32'd4;

    // Redirect outranks both a returning word in REQ and a stall in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetchPc_q   <= RESET_PC;
            inst_q      <= 32'd0;
            pc_q        <= RESET_PC;
            instValid_q <= 1'b0;
            instCount_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetchPc_q <= redirectTarget;
                    end
                    state_q <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        fetchPc_q <= redirectTarget;
                    end else if (imem_ready) begin
                        inst_q      <= imem_rdata;
                        pc_q        <= fetchPc_q;
                        instValid_q <= 1'b1;
                        fetchPc_q   <= fetchPcPlus4;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        instValid_q <= 1'b0;
                        fetchPc_q   <= redirectTarget;
                        state_q     <= REQ;
                    end else if (!stall) begin
                        instValid_q <= 1'b0;
                        instCount_q <= instCount_q + 32'd1;
                        state_q     <= REQ;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    instValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = fetchPc_q;

    assign inst       = inst_q;
    assign inst_valid = instValid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign inst_count = instCount_q;

    // Decoded fields are plain slices of the IR; they remain meaningful while inst_valid is high.
    assign opcode = inst_q[31:26];
    assign rs     = inst_q[25:21];
    assign rt     = inst_q[20:16];
    assign rd     = inst_q[15:11];
    assign shamt  = inst_q[10:6];
    assign funct  = inst_q[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus random stimulus against a transaction-level model;
// a second instance with RESET_PC at the top of memory exercises address wrap.
module tb_inst_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, pc, pc_plus4, inst_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;

    logic [31:0] w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_inst, w_pc, w_pc_plus4, w_count;
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .inst(inst),
        .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .inst_count(inst_count)
    );

    inst_fetch #(.RESET_PC(WRAP_PC)) dutWrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_ready(1'b1), .stall(1'b0),
        .redirect(1'b0), .redirect_pc(32'd0), .inst(w_inst),
        .inst_valid(w_valid), .pc(w_pc), .pc_plus4(w_pc_plus4), .opcode(w_opcode),
        .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct), .inst_count(w_count)
    );

    // Model tracks what the stage holds: whether it is waiting to start, holding a word, and its registers.
    typedef struct {
        bit          starting;
        bit          holding;
        logic [31:0] fetchAddr;
        logic [31:0] word;
        logic [31:0] wordAddr;
        logic [31:0] accepted;
    } model_t;

    model_t m1, m2;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_0020) return 32'h0002_1080;
        return addr | 32'hA000_0000;
    endfunction

    function automatic model_t modelStep(input model_t m, input logic [31:0] resetAddr,
                                         input logic r, input logic redir, input logic [31:0] target,
                                         input logic rdy, input logic stl);
        model_t n = m;
        logic [31:0] aligned = (target / 4) * 4;
        if (r) begin
            n.starting = 1; n.holding = 0; n.fetchAddr = resetAddr;
            n.word = 0; n.wordAddr = resetAddr; n.accepted = 0;
        end else if (m.starting) begin
            n.starting = 0;
            if (redir) n.fetchAddr = aligned;
        end else if (!m.holding) begin
            if (redir) n.fetchAddr = aligned;
            else if (rdy) begin
                n.word = memWord(m.fetchAddr);
                n.wordAddr = m.fetchAddr;
                n.fetchAddr = m.fetchAddr + 4;
                n.holding = 1;
            end
        end else if (redir) begin
            n.holding = 0; n.fetchAddr = aligned;
        end else if (!stl) begin
            n.holding = 0; n.accepted = m.accepted + 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic compareAll();
        logic busy = !m1.starting && !m1.holding;
        checkOutput("req", 32'(imem_req), 32'(busy));
        checkOutput("addr", imem_addr, m1.fetchAddr);
        checkOutput("valid", 32'(inst_valid), 32'(m1.holding));
        checkOutput("inst", inst, m1.word);
        checkOutput("pc", pc, m1.wordAddr);
        checkOutput("pc_plus4", pc_plus4, m1.wordAddr + 4);
        checkOutput("opcode", 32'(opcode), m1.word >> 26);
        checkOutput("rs", 32'(rs), (m1.word >> 21) % 32);
        checkOutput("rt", 32'(rt), (m1.word >> 16) % 32);
        checkOutput("rd", 32'(rd), (m1.word >> 11) % 32);
        checkOutput("shamt", 32'(shamt), (m1.word >> 6) % 32);
        checkOutput("funct", 32'(funct), m1.word % 64);
        checkOutput("count", inst_count, m1.accepted);
        checkOutput("wrap_req", 32'(w_req), 32'(!m2.starting && !m2.holding));
        checkOutput("wrap_addr", w_addr, m2.fetchAddr);
        checkOutput("wrap_valid", 32'(w_valid), 32'(m2.holding));
        checkOutput("wrap_pc", w_pc, m2.wordAddr);
        checkOutput("wrap_pc_plus4", w_pc_plus4, m2.wordAddr + 4);
        checkOutput("wrap_count", w_count, m2.accepted);
    endtask

    task automatic applyStimulus(input logic r, input logic redir, input logic [31:0] target,
                                 input logic rdy, input logic stl);
        rst = r; redirect = redir; redirect_pc = target; imem_ready = rdy; stall = stl;
        imem_rdata = memWord(m1.fetchAddr);
        w_rdata = memWord(m2.fetchAddr);
        m1 = modelStep(m1, 32'h0000_0000, r, redir, target, rdy, stl);
        m2 = modelStep(m2, WRAP_PC, 1'b0 | r, 1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic runUntilHolding(input logic [31:0] wantPc);
        int n = 0;
        while (!(m1.holding && m1.wordAddr == wantPc) && n < 60) begin
            applyStimulus(0, 0, 0, 1, 0);
            n++;
        end
        if (n >= 60) checkOutput("timeout_hold", 32'(n), 32'd0);
    endtask

    initial begin
        logic [31:0] savedCount;
        m1 = modelStep(m1, 32'h0, 1, 0, 0, 0, 0);
        m2 = modelStep(m2, WRAP_PC, 1, 0, 0, 0, 0);
        rst = 1; redirect = 0; redirect_pc = 0; imem_ready = 0; stall = 0;
        imem_rdata = 0; w_rdata = 0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("reset_req", 32'(imem_req), 32'd0);
        checkOutput("reset_count", inst_count, 32'd0);
        checkOutput("reset_inst", inst, 32'd0);

        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("first_req", 32'(imem_req), 32'd1);
        checkOutput("first_addr", imem_addr, 32'd0);
        checkOutput("wrap_first_addr", w_addr, WRAP_PC);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("first_inst", inst, 32'hA000_0000);
        checkOutput("first_valid", 32'(inst_valid), 32'd1);
        checkOutput("wrap_first_pc_plus4", w_pc_plus4, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("second_addr", imem_addr, 32'd4);
        checkOutput("wrap_second_addr", w_addr, 32'd0);
        for (int i = 0; i < 40 && m1.accepted < 4; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("count_after_4", inst_count, 32'd4);

        // Wait states on the fetch from 0x10
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wait_addr", imem_addr, 32'h10);
        checkOutput("wait_valid", 32'(inst_valid), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("wait_latched", inst, 32'hA000_0010);

        // Stall on sll $2,$2,2
        runUntilHolding(32'h20);
        savedCount = m1.accepted;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("stall_inst", inst, 32'h0002_1080);
        checkOutput("stall_shamt", 32'(shamt), 32'd2);
        checkOutput("stall_req", 32'(imem_req), 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("release_count", inst_count, savedCount + 1);
        checkOutput("release_addr", imem_addr, 32'h24);

        // Redirect beats stall in HOLD, then redirect drops a ready word in REQ
        applyStimulus(0, 0, 0, 1, 0);
        savedCount = m1.accepted;
        applyStimulus(0, 1, 32'h0000_0103, 1, 1);
        checkOutput("redir_addr", imem_addr, 32'h100);
        checkOutput("redir_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_count", inst_count, savedCount);
        applyStimulus(0, 1, 32'h0000_0200, 1, 0);
        checkOutput("redir_drop_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_drop_addr", imem_addr, 32'h200);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("redir_target_inst", inst, 32'hA000_0200);

        // Reset in REQ with no ready, then in HOLD
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("midreset_req", 32'(imem_req), 32'd0);
        checkOutput("midreset_count", inst_count, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("midreset2_valid", 32'(inst_valid), 32'd0);
        checkOutput("midreset2_pc", pc, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("midreset2_addr", imem_addr, 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), $urandom,
                          $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
